// File: rtl/race_sequencer.sv
// ============================================================================
// race_sequencer
// ----------------------------------------------------------------------------
// Top-level game controller for the two-player race timer.
//   - Divides the system clock down to a one-cycle second tick.
//   - Runs a start countdown (CD_LEN .. 1) and pulses `go` when it expires.
//   - Gates the enable and clear of the external two-digit BCD elapsed-time
//     counter. That counter lives outside this block; only its digits come back
//     in, and only to detect the 99 s timeout.
//   - Decides which player finished first, and flags false starts (a press
//     during the countdown) and the 99 s timeout.
//
// Parameters
//   TICK_DIV    clock cycles per second tick (>= 2)
//   CD_LEN      countdown start value in seconds (1..9)
//
// Ports
//   clock       system clock
//   reset_n     asynchronous active-low reset
//   start       start request (level); acted on at its rising edge
//   abort       abort (level); returns the block to IDLE
//   p1_done     player 1 finish input; acted on at its rising edge
//   p2_done     player 2 finish input; acted on at its rising edge
//   time_ones   BCD ones digit of the elapsed-time counter
//   time_tens   BCD tens digit of the elapsed-time counter
//   counter_en  one-cycle increment enable to the elapsed-time counter
//   counter_clr one-cycle synchronous clear to the elapsed-time counter
//   sec_tick    one-cycle second pulse
//   cd_digit    countdown digit (BCD) for the HEX display
//   go          one-cycle pulse when the race starts
//   state       0=IDLE 1=COUNTDOWN 2=RUNNING 3=FINISHED
//   winner      0=none 1=P1 2=P2 3=tie
//   false_start a player pressed during the countdown
//   timeout     the race ended at 99 s
// ============================================================================
module race_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int CD_LEN   = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       p1_done,
    input  logic       p2_done,
    input  logic [3:0] time_ones,
    input  logic [3:0] time_tens,
    output logic       counter_en,
    output logic       counter_clr,
    output logic       sec_tick,
    output logic [3:0] cd_digit,
    output logic       go,
    output logic [1:0] state,
    output logic [1:0] winner,
    output logic       false_start,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_RUNNING   = 2'd2,
        S_FINISHED  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        W_NONE = 2'd0,
        W_P1   = 2'd1,
        W_P2   = 2'd2,
        W_TIE  = 2'd3
    } winner_e;

    localparam int               DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]       CD_START = 4'(CD_LEN);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       cd_digit_q, cd_digit_d;
    winner_e          winner_q, winner_d;
    logic             false_start_q, false_start_d;
    logic             timeout_q, timeout_d;
    logic             go_q, go_d;
    logic             counter_clr_q, counter_clr_d;

    // Registered copies of the level inputs, used only for edge detection
    logic             start_q, p1_q, p2_q;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    logic start_edge, p1_edge, p2_edge, any_player;
    logic timing_active, next_timing_active, tick, at_99;

    assign start_edge = start   & ~start_q;
    assign p1_edge    = p1_done & ~p1_q;
    assign p2_edge    = p2_done & ~p2_q;
    assign any_player = p1_edge | p2_edge;

    // The divider only runs while a countdown or race is in progress, so the
    // first tick lands a full second after the countdown begins.
    assign timing_active      = (state_q == S_COUNTDOWN) || (state_q == S_RUNNING);
    assign next_timing_active = (state_d == S_COUNTDOWN) || (state_d == S_RUNNING);
    assign tick               = timing_active && (div_cnt_q == DIV_LAST);
    assign at_99              = (time_tens == 4'd9) && (time_ones == 4'd9);

    // ------------------------------------------------------------------
    // Edge-detect registers
    // ------------------------------------------------------------------
    // NOTE: clocked state is always written with non-blocking assignments so
    // every register samples the values from before the edge, whatever order
    // the simulator evaluates the processes in.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_q <= 1'b0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
        end else begin
            start_q <= start;
            p1_q    <= p1_done;
            p2_q    <= p2_done;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven from an always_comb gets a default on the
    // first line, so no path through the block can leave it unassigned and
    // infer a latch.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_edge) state_d = S_COUNTDOWN;
                end
                S_COUNTDOWN: begin
                    // A false start beats the final tick.
                    if (any_player)                          state_d = S_FINISHED;
                    else if (tick && (cd_digit_q == 4'd1))   state_d = S_RUNNING;
                end
                S_RUNNING: begin
                    if (any_player || (tick && at_99))       state_d = S_FINISHED;
                end
                S_FINISHED: begin
                    if (start_edge) state_d = S_COUNTDOWN;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state: divider, countdown digit, result flags, pulses
    // ------------------------------------------------------------------
    always_comb begin
        cd_digit_d    = cd_digit_q;
        winner_d      = winner_q;
        false_start_d = false_start_q;
        timeout_d     = timeout_q;
        go_d          = 1'b0;
        counter_clr_d = 1'b0;

        // The divider restarts from 0 on every entry into COUNTDOWN and keeps
        // running (wrapping) across the COUNTDOWN -> RUNNING hand-off, so the
        // seconds stay evenly spaced through the start of the race.
        if (abort || !timing_active || !next_timing_active) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (abort) begin
            cd_digit_d    = 4'd0;
            winner_d      = W_NONE;
            false_start_d = 1'b0;
            timeout_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FINISHED: begin
                    if (start_edge) begin
                        cd_digit_d    = CD_START;
                        winner_d      = W_NONE;
                        false_start_d = 1'b0;
                        timeout_d     = 1'b0;
                        counter_clr_d = 1'b1;
                    end
                end
                S_COUNTDOWN: begin
                    if (any_player) begin
                        // The player who jumped the gun forfeits to the other.
                        false_start_d = 1'b1;
                        if (p1_edge && p2_edge) winner_d = W_NONE;
                        else if (p1_edge)       winner_d = W_P2;
                        else                    winner_d = W_P1;
                    end else if (tick) begin
                        cd_digit_d = cd_digit_q - 4'd1;
                        if (cd_digit_q == 4'd1) go_d = 1'b1;
                    end
                end
                S_RUNNING: begin
                    if (any_player) begin
                        // A finish in the timeout tick still counts as a finish.
                        if (p1_edge && p2_edge) winner_d = W_TIE;
                        else if (p1_edge)       winner_d = W_P1;
                        else                    winner_d = W_P2;
                    end else if (tick && at_99) begin
                        timeout_d = 1'b1;
                        winner_d  = W_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q     <= '0;
            cd_digit_q    <= 4'd0;
            winner_q      <= W_NONE;
            false_start_q <= 1'b0;
            timeout_q     <= 1'b0;
            go_q          <= 1'b0;
            counter_clr_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            cd_digit_q    <= cd_digit_d;
            winner_q      <= winner_d;
            false_start_q <= false_start_d;
            timeout_q     <= timeout_d;
            go_q          <= go_d;
            counter_clr_q <= counter_clr_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        sec_tick    = tick;
        // The increment is withheld in the cycle a race ends so the external
        // counter freezes on the finishing time and never wraps past 99.
        counter_en  = (state_q == S_RUNNING) && tick && !any_player && !at_99 && !abort;
        counter_clr = counter_clr_q;
        go          = go_q;
        cd_digit    = cd_digit_q;
        state       = state_q;
        winner      = winner_q;
        false_start = false_start_q;
        timeout     = timeout_q;
    end

endmodule

// File: tb/tb_race_sequencer.sv
// ============================================================================
// tb_race_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for race_sequencer with TICK_DIV=4, CD_LEN=3.
// Inputs are driven just after the falling edge and outputs are sampled 1 time
// unit later, half a period away from the rising (active) edge. Expected
// snapshots are queued when stimulus is driven and popped when the DUT
// presents the result on the following cycle.
// ============================================================================
module tb_race_sequencer;

    localparam int TICK_DIV = 4;
    localparam int CD_LEN   = 3;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic       p1_done = 1'b0;
    logic       p2_done = 1'b0;
    logic [3:0] time_ones = 4'd0;
    logic [3:0] time_tens = 4'd0;

    logic       counter_en, counter_clr, sec_tick, go, false_start, timeout;
    logic [3:0] cd_digit;
    logic [1:0] state, winner;

    always #5 clock = ~clock;

    race_sequencer #(.TICK_DIV(TICK_DIV), .CD_LEN(CD_LEN)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .p1_done     (p1_done),
        .p2_done     (p2_done),
        .time_ones   (time_ones),
        .time_tens   (time_tens),
        .counter_en  (counter_en),
        .counter_clr (counter_clr),
        .sec_tick    (sec_tick),
        .cd_digit    (cd_digit),
        .go          (go),
        .state       (state),
        .winner      (winner),
        .false_start (false_start),
        .timeout     (timeout)
    );

    // Registered-output snapshot: state, winner, false_start, timeout, go, cd
    typedef struct packed {
        logic [1:0] st;
        logic [1:0] win;
        logic       fs;
        logic       to;
        logic       g;
        logic [3:0] cd;
    } snap_t;

    snap_t exp_q[$];
    int    tick_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic snap_t mk(input logic [1:0] st, input logic [1:0] w,
                                 input logic fs, input logic to, input logic g,
                                 input logic [3:0] cd);
        return {st, w, fs, to, g, cd};
    endfunction

    function automatic snap_t obs();
        return {state, winner, false_start, timeout, go, cd_digit};
    endfunction

    task automatic adv();
        @(negedge clock);
    endtask

    task automatic drive(input logic s, input logic a, input logic p1, input logic p2);
        start   = s;
        abort   = a;
        p1_done = p1;
        p2_done = p2;
        #1;
    endtask

    // Advance until sec_tick is high (at most 16 cycles); leaves the bench at
    // the falling edge of the tick cycle with this cycle's inputs not yet driven.
    task automatic wait_tick(input string tag);
        int i;
        adv();
        i = 0;
        while (sec_tick !== 1'b1 && i < 16) begin
            adv();
            i++;
        end
        n_tests++;
        if (sec_tick !== 1'b1) begin
            $display("FAIL %s: no sec_tick within 16 cycles", tag);
            n_fail++;
        end
    endtask

    // Start edge then wait for the go pulse; returns in the go cycle.
    task automatic start_to_running(input string tag);
        int i;
        adv(); drive(1'b1, 1'b0, 1'b0, 1'b0);
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        i = 0;
        while (go !== 1'b1 && i < 30) begin
            adv();
            i++;
        end
        n_tests++;
        if (go !== 1'b1 || state !== 2'd2) begin
            $display("FAIL %s: go=%b state=%0d, required go=1 state=2", tag, go, state);
            n_fail++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) adv();
        #1;
        n_tests++;
        if ({obs(), counter_en, counter_clr, sec_tick} !== 14'd0) begin
            $display("FAIL reset_hold: got %h, required 0", {obs(), counter_en, counter_clr, sec_tick});
            n_fail++;
        end
        adv();
        reset_n = 1'b1;
        repeat (3) adv();
        #1;
        n_tests++;
        if ({obs(), counter_en, counter_clr, sec_tick} !== 14'd0) begin
            $display("FAIL reset_idle: got %h, required 0", {obs(), counter_en, counter_clr, sec_tick});
            n_fail++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_countdown();
        snap_t e;
        int    off;
        int    t;
        logic  pend;
        adv(); drive(1'b1, 1'b0, 1'b0, 1'b0);          // offset 0: start edge
        off = 0;
        n_tests++;
        if (counter_clr !== 1'b0 || state !== 2'd0) begin
            $display("FAIL cd_pre_edge: clr=%b state=%0d, required 0/0", counter_clr, state);
            n_fail++;
        end
        exp_q.push_back(mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 4'd2));
        exp_q.push_back(mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1));
        exp_q.push_back(mk(2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0));
        tick_q.push_back(4);
        tick_q.push_back(8);
        tick_q.push_back(12);

        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0); off++;    // offset 1
        n_tests++;
        if ({counter_clr, state, cd_digit} !== {1'b1, 2'd1, 4'd3}) begin
            $display("FAIL cd_enter: clr/state/cd got %b/%0d/%0d, required 1/1/3", counter_clr, state, cd_digit);
            n_fail++;
        end
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0); off++;    // offset 2
        n_tests++;
        if (counter_clr !== 1'b0) begin
            $display("FAIL cd_clr_width: counter_clr got %b, required 0", counter_clr);
            n_fail++;
        end

        pend = 1'b0;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
            adv(); drive(1'b0, 1'b0, 1'b0, 1'b0); off++;
            if (pend) begin
                e = exp_q.pop_front();
                n_tests++;
                if (obs() !== e) begin
                    $display("FAIL cd_step@%0d: got %h, required %h", off, obs(), e);
                    n_fail++;
                end
            end
            pend = sec_tick;
            if (sec_tick === 1'b1) begin
                n_tests++;
                if (tick_q.size() == 0) begin
                    $display("FAIL cd_tick: unexpected sec_tick at offset %0d", off);
                    n_fail++;
                end else begin
                    t = tick_q.pop_front();
                    if (off != t) begin
                        $display("FAIL cd_tick: tick at offset %0d, required %0d", off, t);
                        n_fail++;
                    end
                end
            end
            n_tests++;
            if (counter_en !== 1'b0) begin
                $display("FAIL cd_en_low@%0d: counter_en got %b, required 0", off, counter_en);
                n_fail++;
            end
        end
        n_tests++;
        if (exp_q.size() != 0 || tick_q.size() != 0) begin
            $display("FAIL cd_bound: %0d snapshots, %0d ticks left unseen", exp_q.size(), tick_q.size());
            n_fail++;
            exp_q.delete();
            tick_q.delete();
        end

        // RUNNING: counter_en follows the tick every TICK_DIV cycles.
        for (int i = 0; i < 8; i++) begin
            adv(); drive(1'b0, 1'b0, 1'b0, 1'b0); off++;
            n_tests++;
            if (counter_en !== ((off == 16) || (off == 20))) begin
                $display("FAIL run_en@%0d: counter_en got %b, required %b", off, counter_en, (off == 16) || (off == 20));
                n_fail++;
            end
            if (off == 14) begin
                n_tests++;
                if (go !== 1'b0) begin
                    $display("FAIL go_width: go got %b, required 0", go);
                    n_fail++;
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_p2_wins();
        snap_t e;
        logic  bad;
        wait_tick("p2_wait");
        drive(1'b0, 1'b0, 1'b0, 1'b1);                  // p2 edge in a tick cycle
        n_tests++;
        if (counter_en !== 1'b0) begin
            $display("FAIL p2_en_gate: counter_en got %b, required 0", counter_en);
            n_fail++;
        end
        exp_q.push_back(mk(2'd3, 2'd2, 1'b0, 1'b0, 1'b0, 4'd0));
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (obs() !== e) begin
            $display("FAIL p2_result: got %h, required %h", obs(), e);
            n_fail++;
        end
        adv(); drive(1'b0, 1'b0, 1'b1, 1'b0);           // late p1 edge
        exp_q.push_back(mk(2'd3, 2'd2, 1'b0, 1'b0, 1'b0, 4'd0));
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (obs() !== e) begin
            $display("FAIL p2_hold: got %h, required %h", obs(), e);
            n_fail++;
        end
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
            if (counter_en !== 1'b0 || sec_tick !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            $display("FAIL fin_quiet: counter_en/sec_tick active in FINISHED, required 0");
            n_fail++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_tie_running();
        snap_t e;
        start_to_running("tie_run_start");
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(mk(2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 4'd0));
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (obs() !== e) begin
            $display("FAIL tie_running: got %h, required %h", obs(), e);
            n_fail++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_false_start();
        snap_t e;
        // p1 alone jumps during the countdown: P2 wins by forfeit.
        adv(); drive(1'b1, 1'b0, 1'b0, 1'b0);
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        adv(); drive(1'b0, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(mk(2'd3, 2'd2, 1'b1, 1'b0, 1'b0, 4'd3));
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (obs() !== e) begin
            $display("FAIL fs_p1: got %h, required %h", obs(), e);
            n_fail++;
        end
        // Both jump together: no winner.
        adv(); drive(1'b1, 1'b0, 1'b0, 1'b0);
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        adv(); drive(1'b0, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(mk(2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 4'd3));
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (obs() !== e) begin
            $display("FAIL fs_both: got %h, required %h", obs(), e);
            n_fail++;
        end
        // p2 jumps in the very tick that would have started the race.
        adv(); drive(1'b1, 1'b0, 1'b0, 1'b0);
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        wait_tick("fs_tick1");
        wait_tick("fs_tick2");
        wait_tick("fs_tick3");
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({state, winner, false_start, go} !== {2'd3, 2'd1, 1'b1, 1'b0}) begin
            $display("FAIL fs_last_tick: state/winner/fs/go got %0d/%0d/%b/%b, required 3/1/1/0", state, winner, false_start, go);
            n_fail++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout();
        snap_t e;
        time_tens = 4'd9;
        time_ones = 4'd9;
        start_to_running("to_start");
        wait_tick("to_wait");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (counter_en !== 1'b0) begin
            $display("FAIL to_en_gate: counter_en got %b, required 0", counter_en);
            n_fail++;
        end
        exp_q.push_back(mk(2'd3, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0));
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (obs() !== e) begin
            $display("FAIL to_result: got %h, required %h", obs(), e);
            n_fail++;
        end
        // Player finishes in the timeout tick: finish wins.
        start_to_running("to_p1_start");
        wait_tick("to_p1_wait");
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (counter_en !== 1'b0) begin
            $display("FAIL to_p1_en_gate: counter_en got %b, required 0", counter_en);
            n_fail++;
        end
        exp_q.push_back(mk(2'd3, 2'd1, 1'b0, 1'b0, 1'b0, 4'd0));
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (obs() !== e) begin
            $display("FAIL to_p1_result: got %h, required %h", obs(), e);
            n_fail++;
        end
        time_tens = 4'd0;
        time_ones = 4'd0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_restart_abort();
        snap_t e;
        logic  bad;
        // Restart from FINISHED (winner=1) with start held high afterwards.
        adv(); drive(1'b1, 1'b0, 1'b0, 1'b0);
        adv(); drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({counter_clr, state, winner, false_start, timeout} !== {1'b1, 2'd1, 2'd0, 1'b0, 1'b0}) begin
            $display("FAIL restart: clr/state/winner/fs/to got %b/%0d/%0d/%b/%b, required 1/1/0/0/0",
                     counter_clr, state, winner, false_start, timeout);
            n_fail++;
        end
        wait_tick("abort_wait");
        adv(); drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (cd_digit !== 4'd2) begin
            $display("FAIL abort_pre: cd_digit got %0d, required 2", cd_digit);
            n_fail++;
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0);                  // abort at cd=2
        exp_q.push_back(mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        adv(); drive(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (obs() !== e || counter_clr !== 1'b0) begin
            $display("FAIL abort: got %h clr=%b, required %h clr=0", obs(), counter_clr, e);
            n_fail++;
        end
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            adv(); drive(1'b1, 1'b0, 1'b0, 1'b0);
            if (state !== 2'd0 || counter_clr !== 1'b0 || go !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            $display("FAIL held_start: left IDLE without a new start edge");
            n_fail++;
        end
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        adv(); drive(1'b1, 1'b0, 1'b0, 1'b0);
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (counter_clr !== 1'b1 || state !== 2'd1) begin
            $display("FAIL new_edge: clr/state got %b/%0d, required 1/1", counter_clr, state);
            n_fail++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        adv(); drive(1'b0, 1'b1, 1'b0, 1'b0);
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        start_to_running("rst_start");
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (state !== 2'd2) begin
            $display("FAIL rst_pre: state got %0d, required 2", state);
            n_fail++;
        end
        #2;                                             // mid low phase, no clock edge
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({obs(), counter_en, counter_clr, sec_tick} !== 14'd0) begin
            $display("FAIL async_reset: got %h, required 0", {obs(), counter_en, counter_clr, sec_tick});
            n_fail++;
        end
        adv();
        reset_n = 1'b1;
        adv(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (state !== 2'd0 || counter_clr !== 1'b0) begin
            $display("FAIL rst_release: state/clr got %0d/%b, required 0/0", state, counter_clr);
            n_fail++;
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_countdown();
        test_p2_wins();
        test_tie_running();
        test_false_start();
        test_timeout();
        test_restart_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/race_sequencer.md
Name: race_sequencer

Overview:
- Top-level game controller for the two-player race timer.
- Generates the 1 Hz second tick and runs a start countdown.
- Gates the enable and clear of the external two-digit BCD elapsed-time counter.
- Arbitrates which player finished first, and flags false starts and the 99 s timeout.

Parameters:
- TICK_DIV, 50000000, clock cycles per second tick (1 Hz at CLOCK_50); must be >= 2.
- CD_LEN, 3, countdown start value in seconds, range 1..9.

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset_n  in  1  asynchronous active-low reset
- start  in  1  start request, level, synchronous; acted on at its rising edge
- abort  in  1  abort, level, synchronous; returns the block to IDLE
- p1_done  in  1  player 1 finish input, synchronous; acted on at its rising edge
- p2_done  in  1  player 2 finish input, synchronous; acted on at its rising edge
- time_ones  in  4  BCD ones digit from the elapsed-time counter
- time_tens  in  4  BCD tens digit from the elapsed-time counter
- counter_en  out  1  one-cycle increment enable to the elapsed-time counter
- counter_clr  out  1  one-cycle synchronous clear to the elapsed-time counter
- sec_tick  out  1  one-cycle second pulse
- cd_digit  out  4  countdown digit in BCD, for HEX display
- go  out  1  one-cycle pulse at race start
- state  out  2  0=IDLE, 1=COUNTDOWN, 2=RUNNING, 3=FINISHED
- winner  out  2  0=none, 1=P1, 2=P2, 3=tie
- false_start  out  1  a player pressed during the countdown
- timeout  out  1  race ended at 99 s

Behaviour:
- Reset (async, reset_n=0): state=IDLE, all outputs 0, divider=0, edge-detect registers=0.
- Edge detect: a rising edge is the input at 1 this cycle and its registered copy at 0. Edges are acted on in the cycle they are seen.
- Divider: div_cnt counts 0..TICK_DIV-1 and wraps, only in COUNTDOWN and RUNNING. It is held at 0 in IDLE and FINISHED.
  - sec_tick = (div_cnt==TICK_DIV-1) and state is COUNTDOWN or RUNNING (combinational).
  - First tick occurs TICK_DIV cycles after entering COUNTDOWN.
- Priority, highest first: reset, abort, everything else.
- abort=1 in any state: next cycle state=IDLE; winner, false_start, timeout, cd_digit all 0; divider cleared. counter_clr is not pulsed.
- IDLE:
  - start edge: go to COUNTDOWN; cd_digit<=CD_LEN; counter_clr=1 for exactly 1 cycle, registered and asserted the cycle after the edge.
  - Player edges are ignored.
- COUNTDOWN:
  - Each sec_tick decrements cd_digit.
  - sec_tick with cd_digit==1: go to RUNNING, cd_digit<=0, go=1 for 1 cycle (registered).
  - Player edge (false start): go to FINISHED, false_start<=1.
    - p1 only: winner<=2.
    - p2 only: winner<=1.
    - Both in the same cycle: winner<=0.
  - A false start in the same cycle as the final tick takes priority over entering RUNNING.
  - counter_en stays 0 throughout.
- RUNNING:
  - counter_en = sec_tick, unless a finish or timeout occurs this cycle (combinational, same cycle as sec_tick).
  - p1 edge only: winner<=1. p2 edge only: winner<=2. Both in the same cycle: winner<=3. Then go to FINISHED.
  - Timeout: sec_tick while time_tens==9 and time_ones==9. Go to FINISHED, timeout<=1, winner<=0, counter_en=0, so the counter holds at 99 (no wrap).
  - A player edge in the same cycle as a timeout tick: the player result wins, timeout stays 0, counter_en=0.
  - Player edges after FINISHED is entered do not change winner.
- FINISHED:
  - Holds winner, false_start, timeout and cd_digit.
  - start edge: behaves as in IDLE (go to COUNTDOWN, counter_clr pulse, flags cleared to 0, winner<=0).
- start held high across transitions produces no repeated restart; only a new rising edge restarts.
- Reset asserted mid-race returns to IDLE immediately and asynchronously; the counter is not cleared until the next start.

Test Plan:
- TICK_DIV=4, CD_LEN=3: reset, pulse start -> counter_clr 1 cycle later for 1 cycle; state=1; cd_digit 3→2→1 at ticks spaced 4 cycles; go pulses with state=2 on the 3rd tick; counter_en pulses every 4 cycles thereafter.
- RUNNING, p2 edge -> state=3, winner=2, counter_en 0 from that cycle on; later p1 edge -> winner stays 2.
- p1 and p2 rising in the same cycle while RUNNING -> winner=3. Same stimulus during COUNTDOWN -> winner=0, false_start=1, state=3.
- Drive time_tens=9, time_ones=9 while RUNNING -> at next sec_tick: counter_en=0, timeout=1, winner=0, state=3. Repeat with p1 edge in the tick cycle -> winner=1, timeout=0.
- abort asserted mid-COUNTDOWN (cd_digit=2) -> next cycle state=0, cd_digit=0, no go, no counter_clr; start held high through abort deassert -> stays IDLE until start falls and rises again.
- From FINISHED (winner=1) new start edge -> counter_clr pulse, winner=0, state=1. Assert reset_n=0 mid-RUNNING -> all outputs 0 without waiting for a clock edge.
